vscale_hasti_arbiter: RTL



---
 rtl/vscale_hasti_arbiter_if.sv | 28 ++
 rtl/vscale_hasti_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vscale_hasti_arbiter_if.sv
// One AHB-Lite (HASTI) port: address phase, write data, read data and response.
// Latency: none, a plain signal bundle.
// Backpressure: carried by hready, driven from the slave side of the port.
interface vscale_hasti_arbiter_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    // Seen from the bus master that issues transfers.
    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    // Seen from the slave that answers transfers.
    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (m0 dmem, m1 imem) to one-slave HASTI arbiter with per-master address-phase buffers.
// Latency: owner issues combinationally; a buffered transfer issues one cycle after capture.
// Backpressure: slave hready stalls owner and data phase; a buffered master sees hready low until issue.
// Option: define VSCALE_HASTI_ARB_DMEM_PRIO_EN to keep the grant on dmem while it streams transfers.
module vscale_hasti_arbiter #(
    parameter int RESET_GNT = 1
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    vscale_hasti_arbiter_if.slave        m0,
    vscale_hasti_arbiter_if.slave        m1,
    vscale_hasti_arbiter_if.master       s
);
    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic        hmastlock;
        logic [3:0]  hprot;
        logic [1:0]  htrans;
    } addr_ph_t;

    localparam logic GNT_RST = (RESET_GNT != 0);

    addr_ph_t   live_ph [2];
    addr_ph_t   buf_q   [2];
    addr_ph_t   sel_ph;
    logic [1:0] live;
    logic [1:0] pend_q;
    logic [1:0] hready;
    logic [1:0] capture;
    logic       gnt_q;
    logic       gnt_d;
    logic       other;
    logic       dp_valid_q;
    logic       dp_own_q;

    // Collect each master's live address phase and decide hready / capture per master.
    always_comb begin
        live_ph[0] = '{haddr: m0.haddr, hwrite: m0.hwrite, hsize: m0.hsize, hburst: m0.hburst,
                       hmastlock: m0.hmastlock, hprot: m0.hprot, htrans: m0.htrans};
        live_ph[1] = '{haddr: m1.haddr, hwrite: m1.hwrite, hsize: m1.hsize, hburst: m1.hburst,
                       hmastlock: m1.hmastlock, hprot: m1.hprot, htrans: m1.htrans};
        live    = '0;
        hready  = '0;
        capture = '0;
        for (int x = 0; x < 2; x++) begin
            live[x] = live_ph[x].htrans[1];
            if (pend_q[x]) begin
                hready[x] = 1'b0;
            end else if ((gnt_q == x[0]) || (dp_valid_q && (dp_own_q == x[0]))) begin
                hready[x] = s.hready;
            end else begin
                hready[x] = 1'b1;
            end
            // A non-owner whose transfer would otherwise be retracted is parked in its buffer.
            capture[x] = (gnt_q != x[0]) && !pend_q[x] && live[x] && hready[x];
        end
    end

    // Owner's address phase: its buffer when one is pending, else its live signals.
    always_comb begin
        sel_ph = pend_q[gnt_q] ? buf_q[gnt_q] : live_ph[gnt_q];
    end

    // Grant moves only on issuing edges, never during a locked sequence.
    always_comb begin
        other = ~gnt_q;
        gnt_d = gnt_q;
        if (s.hready && !sel_ph.hmastlock) begin
            if (pend_q[other] || capture[other]) begin
                gnt_d = other;
            end
`ifdef VSCALE_HASTI_ARB_DMEM_PRIO_EN
            // dmem keeps the bus while it keeps presenting transfers; imem waits for an IDLE.
            if (!gnt_q && live[0]) begin
                gnt_d = 1'b0;
            end
`endif
        end
    end

    // Grant, pending flags and data-phase ownership.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            gnt_q      <= GNT_RST;
            pend_q     <= '0;
            dp_valid_q <= 1'b0;
            dp_own_q   <= 1'b0;
        end else begin
            gnt_q <= gnt_d;
            for (int x = 0; x < 2; x++) begin
                if (capture[x]) begin
                    pend_q[x] <= 1'b1;
                end else if (s.hready && (gnt_q == x[0])) begin
                    pend_q[x] <= 1'b0;
                end
            end
            if (s.hready) begin
                dp_valid_q <= sel_ph.htrans[1];
                dp_own_q   <= gnt_q;
            end
        end
    end

    // Address-phase holding buffers, loaded on capture only.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (capture[x]) begin
                    buf_q[x] <= live_ph[x];
                end
            end
        end
    end

    assign s.haddr     = sel_ph.haddr;
    assign s.hwrite    = sel_ph.hwrite;
    assign s.hsize     = sel_ph.hsize;
    assign s.hburst    = sel_ph.hburst;
    assign s.hmastlock = sel_ph.hmastlock;
    assign s.hprot     = sel_ph.hprot;
    assign s.htrans    = sel_ph.htrans;
    assign s.hwdata    = !dp_valid_q ? 32'h0 : (dp_own_q ? m1.hwdata : m0.hwdata);

    assign m0.hrdata = s.hrdata;
    assign m1.hrdata = s.hrdata;
    assign m0.hready = hready[0];
    assign m1.hready = hready[1];
    assign m0.hresp  = dp_valid_q && !dp_own_q && s.hresp;
    assign m1.hresp  = dp_valid_q && dp_own_q && s.hresp;
endmodule
